// File: rtl/router_pkg.sv
// Shared definitions for the 1-to-N packet router.
//   state_e       : input-side FSM encoding
//   clog2()       : ceiling log2 for parameter-derived widths
//   HdrAddrLsb    : lowest header bit of the destination address field;
//                   the length field sits directly above the address field
package router_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitFull,
    StParity,
    StCheck,
    StDrop
  } state_e;

  localparam int unsigned HdrAddrLsb = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Header LSB of the length field for a router with nports outputs.
  function automatic int unsigned hdr_len_lsb(input int unsigned nports);
    return HdrAddrLsb + clog2(nports);
  endfunction

endpackage

// File: rtl/router_1xn_if.sv
// Packet-side and read-side signal bundle of router_1xn.
//   i_pkt_valid  : header/payload byte marker (low for the parity byte)
//   i_data_in    : input byte
//   i_read_enb   : per-port pop request
//   o_data_out   : port i data on slice [i*WIDTH +: WIDTH]
//   o_valid_out  : per-port FIFO not empty
//   o_busy       : input byte not accepted this cycle
//   o_error      : parity/length mismatch on the last packet
//   o_drop       : one-cycle pulse when a packet is discarded
//   o_soft_reset : one-cycle pulse when a port is flushed by timeout
// Modports: master drives the stimulus side, slave is the router.
interface router_1xn_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NPORTS = 4
) ();
  logic                    i_pkt_valid;
  logic [WIDTH-1:0]        i_data_in;
  logic [NPORTS-1:0]       i_read_enb;
  logic [NPORTS*WIDTH-1:0] o_data_out;
  logic [NPORTS-1:0]       o_valid_out;
  logic                    o_busy;
  logic                    o_error;
  logic                    o_drop;
  logic [NPORTS-1:0]       o_soft_reset;

  modport master (
    output i_pkt_valid, i_data_in, i_read_enb,
    input  o_data_out, o_valid_out, o_busy, o_error, o_drop, o_soft_reset
  );

  modport slave (
    input  i_pkt_valid, i_data_in, i_read_enb,
    output o_data_out, o_valid_out, o_busy, o_error, o_drop, o_soft_reset
  );
endinterface

// File: rtl/router_fifo.sv
// Synchronous WIDTH x DEPTH FIFO with first-word fall-through head.
//   i_clock, i_resetn : clock, async active-low reset (empties the FIFO)
//   i_push, i_wdata   : write request and data (ignored when full)
//   i_pop             : pop request (ignored when empty)
//   i_flush           : empties the FIFO; overrides push and pop
//   o_rdata           : current head word
//   o_full, o_empty   : occupancy flags
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/router_1xn.sv
// 1-to-NPORTS packet router. A packet is header, LEN payload bytes and a
// parity byte; all LEN+2 bytes are stored in the destination port FIFO.
//   i_clock  : sole clock
//   i_resetn : async active-low reset
//   bus      : router_1xn_if slave modport (packet input, read ports, status)
module router_1xn
  import router_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input logic         i_clock,
  input logic         i_resetn,
  router_1xn_if.slave bus
);
  localparam int unsigned AW   = clog2(NPORTS);
  localparam int unsigned LLsb = hdr_len_lsb(NPORTS);
  localparam int unsigned LW   = WIDTH - LLsb;
  localparam int unsigned TW   = clog2(TIMEOUT + 1);
  localparam int unsigned NPad = 1 << AW;

  state_e            r_state, w_state_d;
  logic [AW-1:0]     r_dest, w_hdr_addr, w_push_port;
  logic [LW-1:0]     r_len, w_hdr_len;
  logic [WIDTH-1:0]  r_parity, r_par_byte, r_count;
  logic              r_error, r_drop, w_drop_d;
  logic              w_busy, w_accept, w_push, w_addr_ok, w_hdr_ok;
  logic [NPORTS-1:0] w_full, w_empty, w_tmo;
  // Padded to the full address space so an out-of-range header can index safely.
  logic [NPad-1:0]   w_full_x, w_tmo_x;
  logic [NPORTS*WIDTH-1:0] w_data_out;

  assign w_hdr_addr = bus.i_data_in[HdrAddrLsb +: AW];
  assign w_hdr_len  = bus.i_data_in[LLsb +: LW];
  assign w_addr_ok  = (32'(w_hdr_addr) < NPORTS);
  assign w_hdr_ok   = w_addr_ok & (w_hdr_len != '0);
  assign w_full_x   = NPad'(w_full);
  assign w_tmo_x    = NPad'(w_tmo);

  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      StIdle:             w_busy = bus.i_pkt_valid & w_addr_ok & w_full_x[w_hdr_addr];
      StLoad, StWaitFull: w_busy = w_full_x[r_dest];
      StCheck:            w_busy = 1'b1;
      default:            w_busy = 1'b0;
    endcase
  end

  assign w_accept = ~w_busy & ((r_state == StIdle) ? bus.i_pkt_valid
                                : (r_state inside {StLoad, StWaitFull, StDrop}));

  always_comb begin
    w_state_d   = r_state;
    w_push      = 1'b0;
    w_push_port = r_dest;
    w_drop_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_hdr_ok && !w_tmo_x[w_hdr_addr]) begin
            w_state_d   = StLoad;
            w_push      = 1'b1;
            w_push_port = w_hdr_addr;
          end else begin
            w_state_d = StDrop;
            w_drop_d  = 1'b1;
          end
        end
      end
      StLoad, StWaitFull: begin
        if (w_tmo_x[r_dest]) begin
          // Destination was flushed under us: discard the rest of the packet.
          w_drop_d  = 1'b1;
          w_state_d = (w_accept && !bus.i_pkt_valid) ? StIdle : StDrop;
        end else if (w_accept) begin
          w_push    = 1'b1;
          w_state_d = bus.i_pkt_valid ? StLoad : StCheck;
        end else begin
          w_state_d = w_full_x[r_dest] ? StWaitFull : StLoad;
        end
      end
      StCheck: w_state_d = StIdle;
      StDrop: begin
        if (w_accept && !bus.i_pkt_valid) w_state_d = StIdle;
      end
      // StParity is never entered: the parity byte is absorbed in StLoad.
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= StIdle;
      r_dest     <= '0;
      r_len      <= '0;
      r_parity   <= '0;
      r_par_byte <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_drop  <= w_drop_d;
      if (r_state == StIdle && w_accept) begin
        r_dest   <= w_hdr_addr;
        r_len    <= w_hdr_len;
        r_parity <= bus.i_data_in;
        r_count  <= '0;
        r_error  <= 1'b0;
      end
      if ((r_state == StLoad || r_state == StWaitFull) && w_accept) begin
        if (bus.i_pkt_valid) begin
          r_parity <= r_parity ^ bus.i_data_in;
          r_count  <= r_count + 1'b1;
        end else begin
          r_par_byte <= bus.i_data_in;
        end
      end
      if (r_state == StCheck) begin
        r_error <= (r_parity != r_par_byte) || (r_count != WIDTH'(r_len));
      end
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    logic [TW-1:0]    r_tmo_cnt;
    logic [WIDTH-1:0] r_dout, w_head;
    logic             w_pop;

    assign w_tmo[g] = (r_tmo_cnt == TW'(TIMEOUT));
    assign w_pop    = bus.i_read_enb[g] & ~w_empty[g] & ~w_tmo[g];

    router_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_push   (w_push & (w_push_port == AW'(g))),
      .i_pop    (w_pop),
      .i_flush  (w_tmo[g]),
      .i_wdata  (bus.i_data_in),
      .o_rdata  (w_head),
      .o_full   (w_full[g]),
      .o_empty  (w_empty[g])
    );

    always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
        r_tmo_cnt <= '0;
        r_dout    <= '0;
      end else begin
        if (w_tmo[g])                                 r_tmo_cnt <= '0;
        else if (!w_empty[g] && !bus.i_read_enb[g])   r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else                                          r_tmo_cnt <= '0;
        if (w_pop) r_dout <= w_head;
      end
    end

    assign w_data_out[g*WIDTH +: WIDTH] = r_dout;
  end

  assign bus.o_data_out   = w_data_out;
  assign bus.o_valid_out  = ~w_empty;
  assign bus.o_busy       = w_busy;
  assign bus.o_error      = r_error;
  assign bus.o_drop       = r_drop;
  assign bus.o_soft_reset = w_tmo;
endmodule

// File: tb/tb_router_1xn.sv
module tb_router_1xn;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  router_1xn_if #(.WIDTH(8), .NPORTS(4)) bus ();
  router_1xn_if #(.WIDTH(8), .NPORTS(3)) bus3 ();

  router_1xn #(.WIDTH(8), .NPORTS(4), .DEPTH(16), .TIMEOUT(30)) u_dut (
    .i_clock  (clk),
    .i_resetn (rstn),
    .bus      (bus)
  );

  router_1xn #(.WIDTH(8), .NPORTS(3), .DEPTH(16), .TIMEOUT(30)) u_dut3 (
    .i_clock  (clk),
    .i_resetn (rstn),
    .bus      (bus3)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] pkt [$];
  int stalls;
  int s;
  logic busy_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_pkt(input logic [7:0] hdr, input int len, input logic [7:0] flip);
    logic [7:0] par, b;
    pkt.delete();
    pkt.push_back(hdr);
    par = hdr;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      pkt.push_back(b);
      par ^= b;
    end
    pkt.push_back(par ^ flip);
  endtask

  // Presents one byte and waits (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input logic pv, output int w);
    w = 0;
    bus.i_data_in   = b;
    bus.i_pkt_valid = pv;
    #1;
    while (bus.o_busy === 1'b1 && w < 200) begin
      step();
      w++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(output int st);
    int w;
    st = 0;
    foreach (pkt[i]) begin
      send_byte(pkt[i], logic'(i < int'(pkt.size()) - 1), w);
      st += w;
    end
    bus.i_pkt_valid = 1'b0;
    bus.i_data_in   = 8'h00;
  endtask

  task automatic read_words(input int p, input int n, input string tag);
    bus.i_read_enb = 4'(1 << p);
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("%s_w%0d", tag, k), bus.o_data_out[p*8 +: 8], pkt[k]);
    end
    bus.i_read_enb = 4'b0;
    chk({tag, "_empty"}, bus.o_valid_out, 4'b0);
  endtask

  initial begin
    bus.i_pkt_valid = 1'b0; bus.i_data_in = 8'h00; bus.i_read_enb = 4'b0;
    bus3.i_pkt_valid = 1'b0; bus3.i_data_in = 8'h00; bus3.i_read_enb = 3'b0;
    #12;
    chk("rst_data_out", bus.o_data_out, 32'h0);
    chk("rst_valid_out", bus.o_valid_out, 4'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_error", bus.o_error, 1'b0);
    chk("rst_drop", bus.o_drop, 1'b0);
    chk("rst_soft", bus.o_soft_reset, 4'b0);
    step();
    rstn = 1'b1;
    step();

    // Legal packet, addr 2, LEN 14
    build_pkt(8'h3A, 14, 8'h00);
    send_pkt(stalls);
    chk("t1_no_stall", stalls, 0);
    chk("t1_busy_check", bus.o_busy, 1'b1);
    step();
    chk("t1_busy_after", bus.o_busy, 1'b0);
    chk("t1_error", bus.o_error, 1'b0);
    chk("t1_valid", bus.o_valid_out, 4'b0100);
    read_words(2, 16, "t1_rd");

    // Same packet, parity bit 0 flipped
    build_pkt(8'h3A, 14, 8'h01);
    send_pkt(stalls);
    chk("t2_no_stall", stalls, 0);
    chk("t2_err_in_check", bus.o_error, 1'b0);
    step();
    chk("t2_err_set", bus.o_error, 1'b1);
    step(); step(); step();
    chk("t2_err_hold", bus.o_error, 1'b1);
    read_words(2, 16, "t2_rd");
    chk("t2_err_hold_rd", bus.o_error, 1'b1);

    // LEN 18 packet overflows the FIFO until port 2 is drained
    build_pkt(8'h4A, 18, 8'h00);
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      int w;
      send_byte(pkt[i], 1'b1, w);
      stalls += w;
      if (i == 0) chk("t3_err_clr", bus.o_error, 1'b0);
    end
    chk("t3_no_stall", stalls, 0);
    bus.i_pkt_valid = 1'b1;
    bus.i_data_in   = pkt[16];
    #1;
    chk("t3_busy_full", bus.o_busy, 1'b1);
    chk("t3_valid", bus.o_valid_out, 4'b0100);
    bus.i_read_enb = 4'b0100;
    s = 16;
    busy_acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k >= 1 && s < 20) begin
        bus.i_data_in   = pkt[s];
        bus.i_pkt_valid = logic'(s < 19);
        #1;
        busy_acc |= bus.o_busy;
        s++;
      end else if (k >= 1) begin
        bus.i_pkt_valid = 1'b0;
        bus.i_data_in   = 8'h00;
      end
      @(posedge clk);
      #1;
      chk($sformatf("t3_rd_w%0d", k), bus.o_data_out[23:16], pkt[k]);
    end
    bus.i_read_enb = 4'b0;
    chk("t3_busy_drain", busy_acc, 1'b0);
    chk("t3_empty", bus.o_valid_out, 4'b0);
    chk("t3_error", bus.o_error, 1'b0);

    // LEN 0 header is dropped; next legal packet still routes
    begin
      int w;
      send_byte(8'h01, 1'b1, w);
      chk("t4_drop_pulse", bus.o_drop, 1'b1);
      send_byte(8'h01, 1'b0, w);
      chk("t4_drop_end", bus.o_drop, 1'b0);
      chk("t4_no_valid", bus.o_valid_out, 4'b0);
    end
    bus.i_pkt_valid = 1'b0;
    build_pkt(8'h07, 1, 8'h00);
    send_pkt(stalls);
    chk("t4_no_stall", stalls, 0);
    step();
    chk("t4_valid", bus.o_valid_out, 4'b1000);
    read_words(3, 3, "t4_rd");

    // Address 3 on a 3-port router is dropped
    bus3.i_pkt_valid = 1'b1; bus3.i_data_in = 8'h0F;
    step();
    chk("t4b_drop_pulse", bus3.o_drop, 1'b1);
    chk("t4b_no_valid", bus3.o_valid_out, 3'b0);
    bus3.i_pkt_valid = 1'b0;
    step();
    chk("t4b_drop_end", bus3.o_drop, 1'b0);
    bus3.i_pkt_valid = 1'b1; bus3.i_data_in = 8'h06;
    step();
    bus3.i_data_in = 8'h33;
    step();
    bus3.i_pkt_valid = 1'b0; bus3.i_data_in = 8'h35;
    step();
    bus3.i_data_in = 8'h00;
    step();
    chk("t4b_valid", bus3.o_valid_out, 3'b100);
    chk("t4b_error", bus3.o_error, 1'b0);
    bus3.i_read_enb = 3'b100;
    step(); chk("t4b_rd_w0", bus3.o_data_out[23:16], 8'h06);
    step(); chk("t4b_rd_w1", bus3.o_data_out[23:16], 8'h33);
    step(); chk("t4b_rd_w2", bus3.o_data_out[23:16], 8'h35);
    bus3.i_read_enb = 3'b0;
    chk("t4b_empty", bus3.o_valid_out, 3'b0);

    // Timeout flush of port 1
    build_pkt(8'h05, 1, 8'h00);
    begin
      int w;
      send_byte(pkt[0], 1'b1, w);
      chk("t5_valid_rise", bus.o_valid_out, 4'b0010);
      send_byte(pkt[1], 1'b1, w);
      send_byte(pkt[2], 1'b0, w);
      bus.i_pkt_valid = 1'b0;
    end
    for (int k = 0; k < 27; k++) step();
    chk("t5_soft_early", bus.o_soft_reset, 4'b0);
    step();
    chk("t5_soft_pulse", bus.o_soft_reset, 4'b0010);
    chk("t5_valid_still", bus.o_valid_out, 4'b0010);
    step();
    chk("t5_soft_end", bus.o_soft_reset, 4'b0);
    chk("t5_flushed", bus.o_valid_out, 4'b0);

    // Reset mid-payload
    build_pkt(8'h3A, 14, 8'h00);
    for (int i = 0; i < 6; i++) begin
      int w;
      send_byte(pkt[i], 1'b1, w);
    end
    chk("t6_pre_valid", bus.o_valid_out, 4'b0100);
    rstn = 1'b0;
    bus.i_pkt_valid = 1'b0;
    bus.i_data_in   = 8'h00;
    #1;
    chk("t6_data_out", bus.o_data_out, 32'h0);
    chk("t6_valid_out", bus.o_valid_out, 4'b0);
    chk("t6_busy", bus.o_busy, 1'b0);
    chk("t6_error", bus.o_error, 1'b0);
    chk("t6_drop", bus.o_drop, 1'b0);
    step();
    rstn = 1'b1;
    step();
    build_pkt(8'h3A, 14, 8'h00);
    send_pkt(stalls);
    chk("t6_no_stall", stalls, 0);
    step();
    chk("t6_valid", bus.o_valid_out, 4'b0100);
    chk("t6_err", bus.o_error, 1'b0);
    read_words(2, 16, "t6_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
